// File: rtl/md_pkg.sv
// Shared MD-link types, default widths and the transfer legality rule
// used by the responder and its capture FIFO.
package md_pkg;

  localparam int MD_DATA_W_DEF   = 32;
  localparam int MD_BUS_BYTES_DEF = MD_DATA_W_DEF / 8;
  localparam int MD_OFFSET_W_DEF = 2;
  localparam int MD_SIZE_W_DEF   = 3;
  localparam int MD_FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } md_resp_state_e;

  typedef struct packed {
    logic [MD_DATA_W_DEF-1:0]   data;
    logic [MD_OFFSET_W_DEF-1:0] offset;
    logic [MD_SIZE_W_DEF-1:0]   size;
    logic                       err;
  } md_beat_t;

  // Evaluated in 32 bits so offset+size can never wrap.
  function automatic logic md_is_legal(input int unsigned offset,
                                       input int unsigned size,
                                       input int unsigned bus_bytes);
    return (size != 0) && ((offset + size) <= bus_bytes);
  endfunction

endpackage

// File: rtl/md_resp_fifo.sv
// Synchronous FIFO of captured MD beats; head entry is shown combinationally
// and stays stable until popped. Push on full and pop on empty are ignored.
module md_resp_fifo
  import md_pkg::*;
#(
  parameter type T          = md_beat_t,
  parameter int  FIFO_DEPTH = MD_FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  T                              wdata_i,
  input  logic                          pop_i,
  output T                              rdata_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  T               mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/md_responder.sv
// MD-link sink: waits a programmable delay, answers with a one-cycle md_ready
// (plus md_err for illegal transfers), queues accepted beats and flags misbehaviour.
module md_responder
  import md_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = MD_DATA_W_DEF,
  parameter int BUS_BYTES       = ALGN_DATA_WIDTH / 8,
  parameter int OFFSET_W        = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
  parameter int SIZE_W          = $clog2(BUS_BYTES) + 1,
  parameter int FIFO_DEPTH      = MD_FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          md_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]    md_data,
  input  logic [OFFSET_W-1:0]           md_offset,
  input  logic [SIZE_W-1:0]             md_size,
  output logic                          md_ready,
  output logic                          md_err,
  input  logic [3:0]                    cfg_ready_delay,
  input  logic                          cfg_err_en,
  output logic                          out_valid,
  output logic [ALGN_DATA_WIDTH-1:0]    out_data,
  output logic [OFFSET_W-1:0]           out_offset,
  output logic [SIZE_W-1:0]             out_size,
  output logic                          out_err,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          proto_viol,
  input  logic                          proto_viol_clr
);

  typedef struct packed {
    logic [ALGN_DATA_WIDTH-1:0] data;
    logic [OFFSET_W-1:0]        offset;
    logic [SIZE_W-1:0]          size;
    logic                       err;
  } beat_t;

  md_resp_state_e             state_q;
  logic [3:0]                 cnt_q;
  logic                       md_ready_q;
  logic                       md_err_q;
  logic                       viol_q;
  logic [ALGN_DATA_WIDTH-1:0] cap_data_q;
  logic [OFFSET_W-1:0]        cap_off_q;
  logic [SIZE_W-1:0]          cap_size_q;
  logic                       cap_err_q;

  logic  req_err;
  logic  fifo_full;
  logic  fifo_empty;
  logic  pop;
  logic  push;
  logic  space;
  logic  viol_set;
  beat_t push_beat;
  beat_t head_beat;

  assign req_err = ~md_is_legal(32'(md_offset), 32'(md_size), 32'(BUS_BYTES)) & cfg_err_en;
  assign pop     = ~fifo_empty & out_ready;
  // A pop in the same cycle frees a slot in time for the push from RESP.
  assign space   = ~fifo_full | pop;
  assign push    = (state_q == RESP) & md_valid;

  always_comb begin
    viol_set = 1'b0;
    if (state_q == WAIT) begin
      viol_set = ~md_valid | (md_data != cap_data_q) |
                 (md_offset != cap_off_q) | (md_size != cap_size_q);
    end else if (state_q == RESP) begin
      viol_set = ~md_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      md_ready_q <= 1'b0;
      md_err_q   <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      viol_q     <= viol_set | (viol_q & ~proto_viol_clr);
      md_ready_q <= 1'b0;
      md_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (md_valid) begin
            cnt_q <= cfg_ready_delay;
            if ((cfg_ready_delay == 4'd0) && space) begin
              state_q    <= RESP;
              md_ready_q <= 1'b1;
              md_err_q   <= req_err;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!md_valid) begin
            state_q <= IDLE;
          end else if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Last wait cycle; stay here with cnt=0 while the FIFO is full.
            cnt_q <= '0;
            if (space) begin
              state_q    <= RESP;
              md_ready_q <= 1'b1;
              md_err_q   <= cap_err_q;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && md_valid) begin
      cap_data_q <= md_data;
      cap_off_q  <= md_offset;
      cap_size_q <= md_size;
      cap_err_q  <= req_err;
    end
  end

  assign push_beat.data   = cap_data_q;
  assign push_beat.offset = cap_off_q;
  assign push_beat.size   = cap_size_q;
  assign push_beat.err    = md_err_q;

  md_resp_fifo #(
    .T          (beat_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (head_beat),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign md_ready   = md_ready_q;
  assign md_err     = md_err_q;
  assign proto_viol = viol_q;
  assign out_valid  = ~fifo_empty;
  assign out_data   = head_beat.data;
  assign out_offset = head_beat.offset;
  assign out_size   = head_beat.size;
  assign out_err    = head_beat.err;

endmodule

// File: tb/tb_md_responder.sv
// Scoreboard bench for md_responder: directed scenarios plus randomized traffic,
// with expected responses and FIFO beats queued at issue time and checked by monitors.
module tb_md_responder;

  localparam int DW = 32;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          md_valid;
  logic [DW-1:0] md_data;
  logic [OW-1:0] md_offset;
  logic [SW-1:0] md_size;
  logic          md_ready;
  logic          md_err;
  logic [3:0]    cfg_ready_delay;
  logic          cfg_err_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [OW-1:0] out_offset;
  logic [SW-1:0] out_size;
  logic          out_err;
  logic          out_ready;
  logic [LW-1:0] fifo_level;
  logic          proto_viol;
  logic          proto_viol_clr;

  md_responder dut (
    .clk             (clk),
    .reset           (reset),
    .md_valid        (md_valid),
    .md_data         (md_data),
    .md_offset       (md_offset),
    .md_size         (md_size),
    .md_ready        (md_ready),
    .md_err          (md_err),
    .cfg_ready_delay (cfg_ready_delay),
    .cfg_err_en      (cfg_err_en),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_offset      (out_offset),
    .out_size        (out_size),
    .out_err         (out_err),
    .out_ready       (out_ready),
    .fifo_level      (fifo_level),
    .proto_viol      (proto_viol),
    .proto_viol_clr  (proto_viol_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct { int cyc; bit err; bit exact; } resp_t;
  typedef struct { logic [DW-1:0] data; logic [OW-1:0] off; logic [SW-1:0] size; bit err; } beat_t;
  resp_t rq[$];
  beat_t oq[$];

  bit   rnd_mode = 1'b0;
  logic or_man   = 1'b0;
  logic or_rnd   = 1'b0;
  assign out_ready = rnd_mode ? or_rnd : or_man;
  always @(posedge clk) or_rnd <= ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: illegal when empty or running past the last byte lane.
  function automatic bit model_err(input int off, input int size, input bit en);
    return en && ((size == 0) || (off + size > DW / 8));
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [DW-1:0] d, input int off, input int size,
                           input int dly, input bit en, input bit track, input bit exact);
    bit e;
    md_valid        = 1'b1;
    md_data         = d;
    md_offset       = OW'(off);
    md_size         = SW'(size);
    cfg_ready_delay = 4'(dly);
    cfg_err_en      = en;
    e = model_err(off, size, en);
    if (track) begin
      rq.push_back('{cyc: cyc + 1 + dly, err: e, exact: exact});
      oq.push_back('{data: d, off: OW'(off), size: SW'(size), err: e});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!md_ready && n < 300);
    if (!md_ready) begin
      n_vec++;
      n_mis++;
      $display("FAIL ready_timeout: no md_ready within %0d cycles", n);
    end
    sync();
    md_valid = 1'b0;
  endtask

  task automatic req(input logic [DW-1:0] d, input int off, input int size,
                     input int dly, input bit en, input bit exact);
    start_req(d, off, size, dly, en, 1'b1, exact);
    wait_ready();
  endtask

  task automatic drain();
    int n = 0;
    while (fifo_level != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_level", 64'(fifo_level), 64'd0);
    sync();
  endtask

  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (!reset && md_ready) begin
      if (rq.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_ready: md_ready=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = rq.pop_front();
        check("md_err", 64'(md_err), 64'(e.err));
        if (e.exact) check("ready_cycle", 64'(cyc), 64'(e.cyc));
        else         check("ready_not_early", 64'(cyc >= e.cyc), 64'd1);
      end
    end
  end

  always @(negedge clk) begin : out_mon
    beat_t b;
    if (!reset && out_valid && out_ready) begin
      if (oq.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_out: out_valid=1 data %0h with empty model (cycle %0d)", out_data, cyc);
      end else begin
        b = oq.pop_front();
        check("out_data",   64'(out_data),   64'(b.data));
        check("out_offset", 64'(out_offset), 64'(b.off));
        check("out_size",   64'(out_size),   64'(b.size));
        check("out_err",    64'(out_err),    64'(b.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1;
    md_valid = 1'b0;
    md_data = '0;
    md_offset = '0;
    md_size = '0;
    cfg_ready_delay = '0;
    cfg_err_en = 1'b0;
    proto_viol_clr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_md_ready",   64'(md_ready),   64'd0);
    check("rst_md_err",     64'(md_err),     64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_proto_viol", 64'(proto_viol), 64'd0);
    sync();
    reset = 1'b0;
    sync();

    // Zero delay, legal full-width beat; held in the FIFO for inspection.
    req(32'hA5A5_0F0F, 0, 4, 0, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_out_valid", 64'(out_valid),  64'd1);
    check("t1_level",     64'(fifo_level), 64'd1);
    check("t1_head_data", 64'(out_data),   64'hA5A5_0F0F);
    sync();
    or_man = 1'b1;

    req(32'h1111_2222, 1, 2, 3, 1'b1, 1'b1);
    @(negedge clk);
    check("t2_single_pulse", 64'(md_ready), 64'd0);
    sync();
    req(32'h3333_4444, 2, 3, 1, 1'b1, 1'b1);
    req(32'h5555_6666, 2, 3, 2, 1'b0, 1'b1);
    req(32'h7777_8888, 0, 0, 0, 1'b1, 1'b1);
    req(32'h9999_AAAA, 3, 1, 0, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      req($urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
          ($urandom_range(0, 3) != 0), 1'b1);
    end
    drain();

    // Fill the FIFO; the fifth request must stall until a slot is popped.
    or_man = 1'b0;
    for (int i = 0; i < 4; i++) req(32'hC000_0000 + i, 0, 4, 0, 1'b1, 1'b1);
    start_req(32'hC000_0004, 0, 4, 0, 1'b1, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("t4_stall_ready", 64'(md_ready),   64'd0);
      check("t4_stall_level", 64'(fifo_level), 64'd4);
    end
    sync();
    or_man = 1'b1;
    @(negedge clk);
    check("t4_pop_cycle_ready", 64'(md_ready), 64'd0);
    sync();
    or_man = 1'b0;
    @(negedge clk);
    check("t4_ready_after_pop", 64'(md_ready),   64'd1);
    check("t4_level_after_pop", 64'(fifo_level), 64'd3);
    sync();
    md_valid = 1'b0;
    @(negedge clk);
    check("t4_level_refill", 64'(fifo_level), 64'd4);
    sync();
    or_man = 1'b1;
    drain();

    // Upstream drops md_valid mid-wait: abort, no push, sticky flag.
    start_req(32'hBAD0_0001, 0, 4, 5, 1'b1, 1'b0, 1'b0);
    sync();
    sync();
    md_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_drop_viol",  64'(proto_viol), 64'd1);
    check("t5_drop_level", 64'(fifo_level), 64'd0);
    sync();
    proto_viol_clr = 1'b1;
    sync();
    proto_viol_clr = 1'b0;
    @(negedge clk);
    check("t5_viol_cleared", 64'(proto_viol), 64'd0);
    sync();

    // Data changes during WAIT: flagged, originally captured data is pushed.
    start_req(32'h1234_5678, 1, 2, 2, 1'b1, 1'b1, 1'b1);
    sync();
    md_data = 32'hDEAD_BEEF;
    wait_ready();
    @(negedge clk);
    check("t5_change_viol", 64'(proto_viol), 64'd1);
    sync();
    proto_viol_clr = 1'b1;
    sync();
    proto_viol_clr = 1'b0;
    drain();

    // Random traffic against random consumer back-pressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req($urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
          ($urandom_range(0, 3) != 0), 1'b0);
    end
    rnd_mode = 1'b0;
    or_man = 1'b1;
    drain();

    // Reset while waiting with two beats buffered.
    or_man = 1'b0;
    req(32'hE000_0001, 0, 4, 0, 1'b1, 1'b1);
    req(32'hE000_0002, 0, 4, 0, 1'b1, 1'b1);
    start_req(32'hE000_0003, 0, 4, 5, 1'b1, 1'b0, 1'b0);
    sync();
    sync();
    reset = 1'b1;
    md_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_md_ready",   64'(md_ready),   64'd0);
    check("t6_md_err",     64'(md_err),     64'd0);
    check("t6_out_valid",  64'(out_valid),  64'd0);
    check("t6_fifo_level", 64'(fifo_level), 64'd0);
    check("t6_proto_viol", 64'(proto_viol), 64'd0);
    oq.delete();
    rq.delete();
    sync();
    reset = 1'b0;
    or_man = 1'b1;
    sync();
    req(32'hF00D_CAFE, 1, 3, 1, 1'b1, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    check("resp_queue_empty", 64'(rq.size()), 64'd0);
    check("out_queue_empty",  64'(oq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
